spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//   Byte-wide SPI master peripheral; a new slave on the SoC OBI interconnect, sitting
//   beside gpio/uart and taking the same slave_addr/we/be/wdata/rdata port bundle.
//   Software programs mode/divider, writes a byte, polls busy or takes irq_o, then
//   reads the received byte. Drives external flash/sensor pins.
// PARAMETERS
//   DIV_WIDTH   8     width of SCK divider field CTRL.DIV
//   DIV_RESET   3     reset value of CTRL.DIV
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   addr_i      in   32  byte address; only addr_i[3:2] decoded
//   data_i      in   32  write data
//   sel_i       in   4   byte enables; sel_i[0] gates byte-0 fields, sel_i[1] gates DIV
//   we_i        in   1   write strobe, one clk per access (interconnect-qualified)
//   data_o      out  32  read data, registered
//   irq_o       out  1   one-cycle pulse at transfer completion when CTRL.IE=1
//   spi_sck_o   out  1   serial clock
//   spi_mosi_o  out  1   master out
//   spi_miso_i  in   1   master in (board-synchronous, sampled directly)
//   spi_cs_n_o  out  1   chip select, active low
// BEHAVIOUR
//   Reset: data_o=0, irq_o=0, spi_sck_o=0, spi_mosi_o=0, spi_cs_n_o=1, all regs 0
//     except CTRL.DIV=DIV_RESET; state IDLE.
//   Registers (addr_i[3:2]):
//     0 CTRL  [0]EN [1]CPOL [2]CPHA [3]CS [4]IE [15:8]DIV  (RW)
//     1 TXDATA [7:0] (W; read returns last written byte)
//     2 RXDATA [7:0] (RO)
//     3 STATUS [0]BUSY(RO) [1]RXV(W1C) [2]OVR(W1C)
//   Reads side-effect free; data_o <= selected reg every clk (1-cycle latency, matches
//     interconnect rvalid timing). Unused bits read 0.
//   spi_cs_n_o = ~CTRL.CS, fully software controlled, never touched by the FSM.
//   SCK idles at CTRL.CPOL whenever state=IDLE.
//   Start: write TXDATA with sel_i[0], EN=1, state IDLE -> next cycle BUSY=1,
//     state XFER; CPOL/CPHA/DIV latched at start; shift reg loaded; RXV cleared.
//   XFER: div counter counts 0..DIV; at DIV it wraps and SCK toggles (one "edge").
//     Edges 1..16; odd=leading, even=trailing. Half-period = DIV+1 clk; DIV=0 legal
//     (SCK = clk/2). Transfer = 16*(DIV+1) clk from BUSY rise to edge 16.
//     CPHA=0: MOSI=bit7 at start; sample MISO on odd edges; shift MOSI on even
//       edges 2..14 (no shift after edge 16).
//     CPHA=1: shift out next bit on odd edges (edge 1 drives bit7); sample on even.
//     MSB first both directions.
//   Done: cycle after edge 16 -> RXDATA<=shift reg, RXV=1, BUSY=0, state IDLE,
//     irq_o=1 for exactly that cycle if IE. MOSI holds last bit.
//   TXDATA write while BUSY: ignored for data, OVR<=1. Back-to-back write on the
//     same cycle BUSY falls is accepted (BUSY already 0 in register view).
//   CTRL write while BUSY: stored, effective at next start. Clearing EN while BUSY:
//     abort next cycle, SCK->new CPOL, BUSY=0, RXV unchanged, no irq.
//   W1C write to STATUS in same cycle as done-set of RXV: set wins.
//   Async reset mid-transfer: everything returns to reset values immediately.
// TESTING
//   Mode0 DIV=1, MISO loopback from MOSI, write 0xA5 -> SCK 8 rising edges period 4
//     clk, RXDATA=0xA5, BUSY high 32 clk, irq_o single pulse.
//   Mode3 (CPOL=1,CPHA=1) DIV=0, MISO model returns 0x3C -> SCK idles 1, RXDATA=0x3C,
//     MOSI changes only on falling SCK.
//   Write 0x11 then 0x22 while BUSY -> OVR=1, only 0x11 shifted; W1C STATUS=0x6 clears.
//   Clear EN at edge 5 of a transfer -> BUSY=0 next clk, SCK=CPOL, no irq, RXV=0.
//   Read STATUS/RXDATA repeatedly -> data_o 1 clk after addr change, RXV not cleared.
//   Assert rst_n low at edge 9 -> cs_n=1, sck=0, BUSY=0, DIV reads DIV_RESET.

Source files
------------

// File: rtl/spi_master_if.sv
// Register-bus bundle shared by the SoC peripheral slaves (addr/we/sel/data plus irq).
interface spi_master_if;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [31:0] data_o;
    logic        irq_o;

    modport slave  (input addr_i, data_i, sel_i, we_i, output data_o, irq_o);
    modport master (output addr_i, data_i, sel_i, we_i, input data_o, irq_o);
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI master with CTRL/TXDATA/RXDATA/STATUS registers, all four SPI modes,
// programmable SCK divider and completion interrupt.
module spi_master #(
    parameter int DIV_WIDTH = 8,
    parameter int DIV_RESET = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.slave  bus,
    output logic         spi_sck_o,
    output logic         spi_mosi_o,
    input  logic         spi_miso_i,
    output logic         spi_cs_n_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;
    localparam logic [DIV_WIDTH-1:0] DIV_INIT = DIV_WIDTH'(DIV_RESET);

    logic                 en_reg, cpol_reg, cpha_reg, cs_reg, ie_reg;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [7:0]           tx_reg, rx_reg;
    logic                 rxv_reg, ovr_reg;
    logic [0:0]           state_reg;
    logic                 cpol_lat, cpha_lat;
    logic [DIV_WIDTH-1:0] div_lat, cnt_reg;
    logic [3:0]           edge_reg;
    logic [7:0]           tx_sh_reg, rx_sh_reg;
    logic                 sck_reg, mosi_reg, irq_reg;
    logic [31:0]          data_reg;

    logic       wr_ctrl, wr_tx, wr_status, start, tick, last, odd_edge;
    logic       sample_edge, shift_edge, done;
    logic [4:0] edge_num;
    logic [7:0] rx_next;
    logic [31:0] ctrl_rd;
    logic       unused_bits;

    assign unused_bits = ^{bus.addr_i[31:4], bus.addr_i[1:0], bus.data_i[31:16], bus.sel_i[3:2]};

    always_comb begin
        wr_ctrl   = bus.we_i && (bus.addr_i[3:2] == 2'd0);
        wr_tx     = bus.we_i && (bus.addr_i[3:2] == 2'd1) && bus.sel_i[0];
        wr_status = bus.we_i && (bus.addr_i[3:2] == 2'd3) && bus.sel_i[0];
        start     = wr_tx && en_reg && (state_reg == IDLE);
        tick      = (state_reg == XFER) && en_reg && (cnt_reg == div_lat);
        edge_num  = {1'b0, edge_reg} + 5'd1;
        odd_edge  = edge_num[0];
        last      = (edge_reg == 4'd15);
        // Leading edges are odd; CPHA picks whether leading edges sample or shift.
        sample_edge = tick && (cpha_lat ? !odd_edge : odd_edge);
        shift_edge  = tick && (cpha_lat ? odd_edge : (!odd_edge && !last));
        done        = tick && last;
        rx_next     = {rx_sh_reg[6:0], spi_miso_i};
        ctrl_rd     = '0;
        ctrl_rd[4:0] = {ie_reg, cs_reg, cpha_reg, cpol_reg, en_reg};
        ctrl_rd[8 +: DIV_WIDTH] = div_reg;
    end

    // Software-visible registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg   <= 1'b0;
            cpol_reg <= 1'b0;
            cpha_reg <= 1'b0;
            cs_reg   <= 1'b0;
            ie_reg   <= 1'b0;
            div_reg  <= DIV_INIT;
            tx_reg   <= '0;
            rxv_reg  <= 1'b0;
            ovr_reg  <= 1'b0;
        end else begin
            if (wr_ctrl && bus.sel_i[0])
                {ie_reg, cs_reg, cpha_reg, cpol_reg, en_reg} <= bus.data_i[4:0];
            if (wr_ctrl && bus.sel_i[1])
                div_reg <= bus.data_i[8 +: DIV_WIDTH];
            if (wr_tx && (state_reg == IDLE))
                tx_reg <= bus.data_i[7:0];
            if (wr_tx && (state_reg == XFER))
                ovr_reg <= 1'b1;
            else if (wr_status && bus.data_i[2])
                ovr_reg <= 1'b0;
            // Completion set beats a simultaneous W1C.
            if (done)
                rxv_reg <= 1'b1;
            else if (start || (wr_status && bus.data_i[1]))
                rxv_reg <= 1'b0;
        end
    end

    // Transfer engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cpol_lat  <= 1'b0;
            cpha_lat  <= 1'b0;
            div_lat   <= '0;
            cnt_reg   <= '0;
            edge_reg  <= '0;
            tx_sh_reg <= '0;
            rx_sh_reg <= '0;
            rx_reg    <= '0;
            sck_reg   <= 1'b0;
            mosi_reg  <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            irq_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sck_reg <= cpol_reg;
                    if (start) begin
                        state_reg <= XFER;
                        cpol_lat  <= cpol_reg;
                        cpha_lat  <= cpha_reg;
                        div_lat   <= div_reg;
                        cnt_reg   <= '0;
                        edge_reg  <= '0;
                        rx_sh_reg <= '0;
                        if (cpha_reg) begin
                            tx_sh_reg <= bus.data_i[7:0];
                        end else begin
                            mosi_reg  <= bus.data_i[7];
                            tx_sh_reg <= {bus.data_i[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    if (!en_reg) begin
                        state_reg <= IDLE;
                        sck_reg   <= cpol_reg;
                    end else if (tick) begin
                        cnt_reg  <= '0;
                        sck_reg  <= ~sck_reg;
                        edge_reg <= edge_reg + 4'd1;
                        if (sample_edge)
                            rx_sh_reg <= rx_next;
                        if (shift_edge) begin
                            mosi_reg  <= tx_sh_reg[7];
                            tx_sh_reg <= {tx_sh_reg[6:0], 1'b0};
                        end
                        if (last) begin
                            state_reg <= IDLE;
                            rx_reg    <= sample_edge ? rx_next : rx_sh_reg;
                            irq_reg   <= ie_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else begin
            case (bus.addr_i[3:2])
                2'd0:    data_reg <= ctrl_rd;
                2'd1:    data_reg <= {24'd0, tx_reg};
                2'd2:    data_reg <= {24'd0, rx_reg};
                default: data_reg <= {29'd0, ovr_reg, rxv_reg, (state_reg == XFER)};
            endcase
        end
    end

    assign bus.data_o = data_reg;
    assign bus.irq_o  = irq_reg;
    assign spi_sck_o  = sck_reg;
    assign spi_mosi_o = mosi_reg;
    assign spi_cs_n_o = ~cs_reg;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: mode 0 loopback, mode 3 slave model, overrun,
// abort, repeated reads and mid-transfer reset.
module tb_spi_master;
    logic clk, rst_n;
    logic spi_sck, spi_mosi, spi_miso, spi_cs_n;
    logic loop_en, slave_rst, slave_bit;
    logic [7:0] slave_sh;
    int checks, failures;

    spi_master_if bus();

    spi_master #(.DIV_WIDTH(8), .DIV_RESET(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_sck_o(spi_sck), .spi_mosi_o(spi_mosi),
        .spi_miso_i(spi_miso), .spi_cs_n_o(spi_cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-3 slave: presents next bit on every falling SCK.
    always @(negedge spi_sck or posedge slave_rst) begin
        if (slave_rst) begin
            slave_sh  <= 8'h3C;
            slave_bit <= 1'b0;
        end else begin
            slave_bit <= slave_sh[7];
            slave_sh  <= {slave_sh[6:0], 1'b0};
        end
    end

    assign spi_miso = loop_en ? spi_mosi : slave_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        bus.addr_i = addr;
        bus.data_i = data;
        bus.sel_i  = sel;
        bus.we_i   = 1'b1;
        tick();
        bus.we_i   = 1'b0;
        bus.sel_i  = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.addr_i = addr;
        bus.we_i   = 1'b0;
        tick();
        data = bus.data_o;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        bus.addr_i = 32'hC;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (n >= 2 && bus.data_o[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int rises, last_rise, period_bad, busy_cnt, irq_cnt, toggles, bad;
        logic prev_sck, prev_mosi;

        checks = 0; failures = 0;
        rst_n = 1'b0; loop_en = 1'b1; slave_rst = 1'b0;
        bus.addr_i = '0; bus.data_i = '0; bus.sel_i = '0; bus.we_i = 1'b0;
        repeat (3) tick();
        check("rst_sck", {31'd0, spi_sck}, 32'd0);
        check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_irq", {31'd0, bus.irq_o}, 32'd0);
        check("rst_data_o", bus.data_o, 32'd0);
        rst_n = 1'b1;
        tick();
        bus_read(32'h0, rd);
        check("rst_ctrl", rd, 32'h0000_0300);
        bus_read(32'hC, rd);
        check("rst_status", rd, 32'h0);

        // Mode 0, DIV=1, loopback, 0xA5
        bus_write(32'h0, 32'h0000_0119, 4'b0011);
        bus_read(32'h0, rd);
        check("ctrl_readback", rd, 32'h0000_0119);
        check("cs_active", {31'd0, spi_cs_n}, 32'd0);
        bus_write(32'h4, 32'h0000_00A5, 4'b0001);
        bus.addr_i = 32'hC;
        rises = 0; last_rise = 0; period_bad = 0; busy_cnt = 0; irq_cnt = 0;
        prev_sck = spi_sck;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (spi_sck && !prev_sck) begin
                if (rises > 0 && (i - last_rise) != 4) period_bad++;
                rises++;
                last_rise = i;
            end
            prev_sck = spi_sck;
            if (bus.data_o[0]) busy_cnt++;
            if (bus.irq_o) irq_cnt++;
        end
        check("m0_sck_rises", rises, 32'd8);
        check("m0_sck_period_bad", period_bad, 32'd0);
        check("m0_busy_cycles", busy_cnt, 32'd32);
        check("m0_irq_pulses", irq_cnt, 32'd1);
        check("m0_mosi_hold", {31'd0, spi_mosi}, 32'd1);
        bus_read(32'h8, rd);
        check("m0_rxdata", rd, 32'hA5);

        // Repeated reads alternate RXDATA/STATUS; RXV must persist
        for (int k = 0; k < 3; k++) begin
            bus.addr_i = 32'h8;
            #1;
            check("rr_before_edge", bus.data_o, (k == 0) ? 32'hA5 : 32'h2);
            tick();
            check("rr_rxdata", bus.data_o, 32'hA5);
            bus.addr_i = 32'hC;
            tick();
            check("rr_status", bus.data_o, 32'h2);
        end

        // Abort at edge 5 by clearing EN
        bus_write(32'h4, 32'h0000_00F0, 4'b0001);
        toggles = 0; irq_cnt = 0;
        prev_sck = spi_sck;
        for (int i = 0; i < 60 && toggles < 5; i++) begin
            tick();
            if (spi_sck != prev_sck) toggles++;
            prev_sck = spi_sck;
            if (bus.irq_o) irq_cnt++;
        end
        check("ab_reached_edge5", toggles, 32'd5);
        bus_write(32'h0, 32'h0000_0118, 4'b0011);
        if (bus.irq_o) irq_cnt++;
        tick();
        check("ab_sck_cpol", {31'd0, spi_sck}, 32'd0);
        bus_read(32'hC, rd);
        check("ab_status", rd, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (bus.irq_o) irq_cnt++;
            tick();
        end
        check("ab_no_irq", irq_cnt, 32'd0);

        // Mode 3, DIV=0, slave returns 0x3C
        loop_en = 1'b0;
        bus_write(32'h0, 32'h0000_000F, 4'b0011);
        tick();
        check("m3_sck_idle", {31'd0, spi_sck}, 32'd1);
        slave_rst = 1'b1;
        #1;
        slave_rst = 1'b0;
        bus_write(32'h4, 32'h0000_0096, 4'b0001);
        bad = 0;
        prev_sck = spi_sck; prev_mosi = spi_mosi;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (spi_mosi != prev_mosi && !(prev_sck && !spi_sck)) bad++;
            prev_sck = spi_sck; prev_mosi = spi_mosi;
        end
        check("m3_mosi_on_fall", bad, 32'd0);
        check("m3_sck_idle_after", {31'd0, spi_sck}, 32'd1);
        check("m3_mosi_last", {31'd0, spi_mosi}, 32'd0);
        bus_read(32'h8, rd);
        check("m3_rxdata", rd, 32'h3C);

        // Overrun: second TXDATA write while busy is dropped
        loop_en = 1'b1;
        bus_write(32'h0, 32'h0000_0109, 4'b0011);
        bus_write(32'h4, 32'h0000_0011, 4'b0001);
        bus_write(32'h4, 32'h0000_0022, 4'b0001);
        wait_idle();
        bus_read(32'h8, rd);
        check("ovr_rxdata", rd, 32'h11);
        bus_read(32'h4, rd);
        check("ovr_txdata", rd, 32'h11);
        bus_read(32'hC, rd);
        check("ovr_status", rd, 32'h6);
        bus_write(32'hC, 32'h0000_0006, 4'b0001);
        bus_read(32'hC, rd);
        check("w1c_status", rd, 32'h0);

        // Asynchronous reset at edge 9
        bus_write(32'h0, 32'h0000_0509, 4'b0011);
        bus_write(32'h4, 32'h0000_005A, 4'b0001);
        toggles = 0;
        prev_sck = spi_sck;
        for (int i = 0; i < 200 && toggles < 9; i++) begin
            tick();
            if (spi_sck != prev_sck) toggles++;
            prev_sck = spi_sck;
        end
        check("rs_reached_edge9", toggles, 32'd9);
        check("rs_sck_high_before", {31'd0, spi_sck}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rs_sck", {31'd0, spi_sck}, 32'd0);
        check("rs_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rs_data_o", bus.data_o, 32'd0);
        tick();
        rst_n = 1'b1;
        bus_read(32'h0, rd);
        check("rs_ctrl_div", rd, 32'h0000_0300);
        bus_read(32'hC, rd);
        check("rs_status", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
